// File: rtl/keypad_digit_buffer_pkg.sv
// Shared constants, register-operation encodings and the keypad priority encoder
// used by the keypad digit buffer and its digit registers.
package keypad_pkg;

    localparam int NUM_REGS = 8;
    localparam int DIGIT_W  = 4;

    typedef enum logic [1:0] {
        MODE_HOLD = 2'b00,
        MODE_SHR  = 2'b01,
        MODE_SHL  = 2'b10,
        MODE_LOAD = 2'b11
    } mode_e;

    // Later (higher) keys overwrite earlier ones, so the highest pressed index wins.
    function automatic logic [4:0] enc10to5(input logic [9:0] keys);
        logic [4:0] code;
        code = 5'b0_0000;
        for (int i = 0; i < 10; i++) begin
            if (keys[i]) begin
                code = {1'b1, 4'(i)};
            end
        end
        return code;
    endfunction

endpackage

// File: rtl/keypad_digit_buffer_if.sv
// Keypad-side inputs and digit-buffer outputs bundled for the keypad digit buffer.
// The master side drives keys and controls; the slave side is the buffer itself.
interface keypad_digit_buffer_if;
    import keypad_pkg::*;

    logic [9:0]         x;
    logic               sel;
    logic [1:0]         mode;
    logic [4:0]         enc_out;
    logic [1:0]         mode_out;
    logic [2:0]         wr_ptr;
    logic [DIGIT_W-1:0] reg_out1;
    logic [DIGIT_W-1:0] reg_out2;
    logic [DIGIT_W-1:0] reg_out3;
    logic [DIGIT_W-1:0] reg_out4;
    logic [DIGIT_W-1:0] reg_out5;
    logic [DIGIT_W-1:0] reg_out6;
    logic [DIGIT_W-1:0] reg_out7;
    logic [DIGIT_W-1:0] reg_out8;

    modport master (
        output x, sel, mode,
        input  enc_out, mode_out, wr_ptr,
        input  reg_out1, reg_out2, reg_out3, reg_out4,
        input  reg_out5, reg_out6, reg_out7, reg_out8
    );

    modport slave (
        input  x, sel, mode,
        output enc_out, mode_out, wr_ptr,
        output reg_out1, reg_out2, reg_out3, reg_out4,
        output reg_out5, reg_out6, reg_out7, reg_out8
    );

endinterface

// File: rtl/keypad_digit_buffer_digit_shift_reg.sv
// One 4-bit universal digit register: hold, shift right/left with zero fill,
// or parallel load, applied only on cycles where en is high.
module digit_shift_reg
    import keypad_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic [1:0]         mode,
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] q
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (en) begin
            case (mode_e'(mode))
                MODE_SHR:  q <= {1'b0, q[DIGIT_W-1:1]};
                MODE_SHL:  q <= {q[DIGIT_W-2:0], 1'b0};
                MODE_LOAD: q <= din;
                default:   q <= q;
            endcase
        end
    end

endmodule

// File: rtl/keypad_digit_buffer.sv
// Keypad front end: encodes the one-hot keypad to BCD, turns each new press into a
// single strobe, and steers entry strobes into eight digit registers in turn.
module keypad_digit_buffer
    import keypad_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst_ui,
    keypad_digit_buffer_if.slave bus
);

    logic [4:0]         enc;
    logic [4:0]         enc_q;
    logic               valid_d;
    logic               sel_q;
    logic               press;
    logic               entry;
    logic [2:0]         wr_ptr;
    logic [DIGIT_W-1:0] digits [NUM_REGS];

    assign enc          = enc10to5(bus.x);
    assign bus.enc_out  = enc;
    assign bus.mode_out = {enc[4] & bus.sel, enc[4] & ~bus.sel};

    // sel is captured with the encoded key so the strobe uses the path chosen at press time.
    always_ff @(posedge clk or negedge rst_ui) begin
        if (!rst_ui) begin
            enc_q   <= '0;
            valid_d <= 1'b0;
            sel_q   <= 1'b0;
        end else begin
            enc_q   <= enc;
            valid_d <= enc_q[4];
            sel_q   <= bus.sel;
        end
    end

    assign press = enc_q[4] & ~valid_d;
    assign entry = press & ~sel_q;

    always_ff @(posedge clk or negedge rst_ui) begin
        if (!rst_ui) begin
            wr_ptr <= '0;
        end else if (entry) begin
            wr_ptr <= wr_ptr + 3'd1;
        end
    end

    assign bus.wr_ptr = wr_ptr;

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_digit
        digit_shift_reg u_digit (
            .clk   (clk),
            .rst_n (rst_ui),
            .en    (entry && (wr_ptr == 3'(i))),
            .mode  (bus.mode),
            .din   (enc_q[3:0]),
            .q     (digits[i])
        );
    end

    assign bus.reg_out1 = digits[0];
    assign bus.reg_out2 = digits[1];
    assign bus.reg_out3 = digits[2];
    assign bus.reg_out4 = digits[3];
    assign bus.reg_out5 = digits[4];
    assign bus.reg_out6 = digits[5];
    assign bus.reg_out7 = digits[6];
    assign bus.reg_out8 = digits[7];

endmodule

// File: tb/tb_keypad_digit_buffer.sv
// Bench for keypad_digit_buffer: a register-file model predicts each press, and the
// expected entry is queued at stimulus time and compared once the press has landed.
module tb_keypad_digit_buffer;
    import keypad_pkg::*;

    typedef struct {
        int         idx;
        logic [3:0] val;
        logic [2:0] ptr;
    } exp_t;

    logic clk = 1'b0;
    logic rst_ui;

    keypad_digit_buffer_if bus ();

    keypad_digit_buffer dut (
        .clk    (clk),
        .rst_ui (rst_ui),
        .bus    (bus.slave)
    );

    always #5 clk = ~clk;

    int         vectors     = 0;
    int         miscompares = 0;
    exp_t       sb [$];
    logic [3:0] exp_regs [8];
    logic [2:0] exp_ptr;

    function automatic logic [3:0] get_reg(input int i);
        case (i)
            0:       return bus.reg_out1;
            1:       return bus.reg_out2;
            2:       return bus.reg_out3;
            3:       return bus.reg_out4;
            4:       return bus.reg_out5;
            5:       return bus.reg_out6;
            6:       return bus.reg_out7;
            7:       return bus.reg_out8;
            default: return 4'hx;
        endcase
    endfunction

    function automatic void model_reset();
        for (int i = 0; i < 8; i++) exp_regs[i] = 4'h0;
        exp_ptr = 3'd0;
    endfunction

    // Predicts the effect of one press with the current sel/mode and queues it.
    function automatic void model_press(input logic [3:0] key, input logic s, input logic [1:0] m);
        exp_t       e;
        logic [3:0] r;
        int         i;
        i = int'(exp_ptr);
        r = exp_regs[i];
        if (!s) begin
            case (m)
                2'b01:   r = {1'b0, r[3:1]};
                2'b10:   r = {r[2:0], 1'b0};
                2'b11:   r = key;
                default: r = r;
            endcase
            exp_regs[i] = r;
            exp_ptr     = exp_ptr + 3'd1;
        end
        e.idx = i;
        e.val = r;
        e.ptr = exp_ptr;
        sb.push_back(e);
    endfunction

    task automatic applyStimulus(input logic [3:0] key, input int hold, input int rel);
        model_press(key, bus.sel, bus.mode);
        bus.x = 10'd1 << key;
        repeat (hold) @(negedge clk);
        bus.x = '0;
        repeat (rel) @(negedge clk);
    endtask

    task automatic quick_reset();
        @(negedge clk);
        rst_ui = 1'b0;
        @(negedge clk);
        rst_ui = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        rst_ui   = 1'b0;
        bus.x    = '0;
        bus.sel  = 1'b0;
        bus.mode = 2'b11;
        model_reset();
        repeat (2) @(negedge clk);
        vectors++;
        if (bus.wr_ptr !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL reset_ptr: got %0d expected 0", bus.wr_ptr);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (get_reg(i) !== 4'h0) begin
                miscompares++;
                $display("[TB] FAIL reset_reg%0d: got %h expected 0", i + 1, get_reg(i));
            end
        end
        vectors++;
        if (bus.enc_out !== 5'b0_0000) begin
            miscompares++;
            $display("[TB] FAIL enc_none: got %b expected 00000", bus.enc_out);
        end
        bus.x = 10'b00_0000_0001;
        #1;
        vectors++;
        if (bus.enc_out !== 5'b1_0000) begin
            miscompares++;
            $display("[TB] FAIL enc_key0_in_reset: got %b expected 10000", bus.enc_out);
        end
        bus.x = 10'b00_0010_0000;
        #1;
        vectors++;
        if (bus.enc_out !== 5'b1_0101 || bus.mode_out !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL enc_key5_in_reset: got %b/%b expected 10101/01", bus.enc_out, bus.mode_out);
        end
        bus.x = '0;
        @(negedge clk);
        rst_ui = 1'b1;
    endtask

    task automatic test_entry_sequence();
        logic [3:0] keys [8] = '{4'd2, 4'd1, 4'd9, 4'd3, 4'd5, 4'd4, 4'd8, 4'd8};
        exp_t       e;
        bus.sel  = 1'b0;
        bus.mode = 2'b11;
        for (int k = 0; k < 8; k++) begin
            model_press(keys[k], bus.sel, bus.mode);
            bus.x = 10'd1 << keys[k];
            repeat (5) @(negedge clk);
            if (k == 0) begin
                vectors++;
                if (bus.enc_out !== 5'b1_0010) begin
                    miscompares++;
                    $display("[TB] FAIL enc_key2: got %b expected 10010", bus.enc_out);
                end
            end
            bus.x = '0;
            repeat (5) @(negedge clk);
            e = sb.pop_front();
            vectors++;
            if (get_reg(e.idx) !== e.val || bus.wr_ptr !== e.ptr) begin
                miscompares++;
                $display("[TB] FAIL entry_press%0d: got reg=%h ptr=%0d expected reg=%h ptr=%0d",
                         k, get_reg(e.idx), bus.wr_ptr, e.val, e.ptr);
            end
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (get_reg(i) !== keys[i]) begin
                miscompares++;
                $display("[TB] FAIL entry_final_reg%0d: got %h expected %h", i + 1, get_reg(i), keys[i]);
            end
        end
        vectors++;
        if (bus.wr_ptr !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL entry_wrap_ptr: got %0d expected 0", bus.wr_ptr);
        end
    endtask

    task automatic test_wrap();
        logic [3:0] rest [8] = '{4'd7, 4'd1, 4'd9, 4'd3, 4'd5, 4'd4, 4'd8, 4'd8};
        exp_t       e;
        applyStimulus(4'd7, 5, 5);
        e = sb.pop_front();
        vectors++;
        if (get_reg(e.idx) !== e.val || bus.wr_ptr !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL wrap_press: got reg=%h ptr=%0d expected reg=%h ptr=1",
                     get_reg(e.idx), bus.wr_ptr, e.val);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (get_reg(i) !== rest[i]) begin
                miscompares++;
                $display("[TB] FAIL wrap_reg%0d: got %h expected %h", i + 1, get_reg(i), rest[i]);
            end
        end
    endtask

    task automatic test_hold_multikey();
        exp_t       e;
        logic [2:0] p;
        p = bus.wr_ptr;
        applyStimulus(4'd3, 20, 5);
        e = sb.pop_front();
        vectors++;
        if (get_reg(e.idx) !== e.val || bus.wr_ptr !== 3'(p + 3'd1)) begin
            miscompares++;
            $display("[TB] FAIL long_hold: got reg=%h ptr=%0d expected reg=%h ptr=%0d",
                     get_reg(e.idx), bus.wr_ptr, e.val, 3'(p + 3'd1));
        end
        model_press(4'd9, bus.sel, bus.mode);
        bus.x = 10'b10_0000_1000;
        #1;
        vectors++;
        if (bus.enc_out !== 5'b1_1001) begin
            miscompares++;
            $display("[TB] FAIL priority_9_3: got %b expected 11001", bus.enc_out);
        end
        repeat (5) @(negedge clk);
        bus.x = '0;
        repeat (5) @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (get_reg(e.idx) !== e.val || bus.wr_ptr !== e.ptr) begin
            miscompares++;
            $display("[TB] FAIL priority_write: got reg=%h ptr=%0d expected reg=%h ptr=%0d",
                     get_reg(e.idx), bus.wr_ptr, e.val, e.ptr);
        end
        model_press(4'd3, bus.sel, bus.mode);
        bus.x = 10'b00_0000_1000;
        repeat (3) @(negedge clk);
        bus.x = 10'b00_0001_1000;
        repeat (5) @(negedge clk);
        bus.x = '0;
        repeat (5) @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (get_reg(e.idx) !== 4'd3 || bus.wr_ptr !== e.ptr) begin
            miscompares++;
            $display("[TB] FAIL key_change_held: got reg=%h ptr=%0d expected reg=3 ptr=%0d",
                     get_reg(e.idx), bus.wr_ptr, e.ptr);
        end
    endtask

    task automatic test_alternate();
        exp_t e;
        bus.sel = 1'b1;
        model_press(4'd6, bus.sel, bus.mode);
        bus.x = 10'd1 << 6;
        #1;
        vectors++;
        if (bus.mode_out !== 2'b10) begin
            miscompares++;
            $display("[TB] FAIL alt_mode_out: got %b expected 10", bus.mode_out);
        end
        repeat (5) @(negedge clk);
        bus.sel = 1'b0;
        #1;
        vectors++;
        if (bus.mode_out !== 2'b01) begin
            miscompares++;
            $display("[TB] FAIL entry_mode_out: got %b expected 01", bus.mode_out);
        end
        repeat (2) @(negedge clk);
        bus.x = '0;
        repeat (5) @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (bus.wr_ptr !== e.ptr) begin
            miscompares++;
            $display("[TB] FAIL alt_ptr: got %0d expected %0d", bus.wr_ptr, e.ptr);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (get_reg(i) !== exp_regs[i]) begin
                miscompares++;
                $display("[TB] FAIL alt_reg%0d: got %h expected %h", i + 1, get_reg(i), exp_regs[i]);
            end
        end
    endtask

    task automatic test_modes();
        logic [3:0] keys  [12] = '{4'd9, 4'd9, 4'd6, 4'd5, 4'd1, 4'd1, 4'd1, 4'd1,
                                   4'd1, 4'd1, 4'd1, 4'd1};
        logic [1:0] modes [12] = '{2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 2'b00, 2'b00, 2'b00,
                                   2'b01, 2'b10, 2'b10, 2'b00};
        logic [3:0] final_regs [4] = '{4'b0100, 4'b0010, 4'b1100, 4'b0101};
        exp_t       e;
        quick_reset();
        bus.sel = 1'b0;
        for (int k = 0; k < 12; k++) begin
            bus.mode = modes[k];
            applyStimulus(keys[k], 4, 3);
            e = sb.pop_front();
            vectors++;
            if (get_reg(e.idx) !== e.val || bus.wr_ptr !== e.ptr) begin
                miscompares++;
                $display("[TB] FAIL mode_step%0d: got reg=%h ptr=%0d expected reg=%h ptr=%0d",
                         k, get_reg(e.idx), bus.wr_ptr, e.val, e.ptr);
            end
        end
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (get_reg(i) !== final_regs[i]) begin
                miscompares++;
                $display("[TB] FAIL mode_final_reg%0d: got %b expected %b", i + 1, get_reg(i), final_regs[i]);
            end
        end
        vectors++;
        if (bus.wr_ptr !== 3'd4) begin
            miscompares++;
            $display("[TB] FAIL mode_final_ptr: got %0d expected 4", bus.wr_ptr);
        end
        bus.mode = 2'b11;
    endtask

    task automatic test_reset_mid();
        exp_t e;
        bus.sel  = 1'b0;
        bus.mode = 2'b11;
        model_press(4'd2, bus.sel, bus.mode);
        bus.x = 10'd1 << 2;
        repeat (3) @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (get_reg(e.idx) !== e.val || bus.wr_ptr !== e.ptr) begin
            miscompares++;
            $display("[TB] FAIL pre_reset_write: got reg=%h ptr=%0d expected reg=%h ptr=%0d",
                     get_reg(e.idx), bus.wr_ptr, e.val, e.ptr);
        end
        #2;
        rst_ui = 1'b0;
        #1;
        model_reset();
        vectors++;
        if (bus.wr_ptr !== 3'd0) begin
            miscompares++;
            $display("[TB] FAIL async_reset_ptr: got %0d expected 0", bus.wr_ptr);
        end
        for (int i = 0; i < 8; i++) begin
            vectors++;
            if (get_reg(i) !== 4'h0) begin
                miscompares++;
                $display("[TB] FAIL async_reset_reg%0d: got %h expected 0", i + 1, get_reg(i));
            end
        end
        repeat (3) @(negedge clk);
        rst_ui = 1'b1;
        model_press(4'd2, bus.sel, bus.mode);
        repeat (2) @(negedge clk);
        e = sb.pop_front();
        vectors++;
        if (bus.reg_out1 !== 4'd2 || e.idx != 0 || bus.wr_ptr !== 3'd1) begin
            miscompares++;
            $display("[TB] FAIL post_reset_write: got reg1=%h ptr=%0d expected reg1=2 ptr=1",
                     bus.reg_out1, bus.wr_ptr);
        end
        bus.x = '0;
        repeat (3) @(negedge clk);
    endtask

    initial begin
        test_reset();
        test_entry_sequence();
        test_wrap();
        test_hold_multikey();
        test_alternate();
        test_modes();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
